ifm_pingpong_ctrl: RTL and testbench

//  Sequences the IFM ping-pong input buffer. Accepts a valid/ready IFM beat stream and cuts it into tiles of

---
 rtl/ifm_pingpong_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_ifm_pingpong_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_pingpong_ctrl.sv
// ifm_pingpong_ctrl
//   Sequences the IFM ping-pong input buffer. A valid/ready beat stream is cut
//   into tiles of tile_len beats that land alternately in bank 0 and bank 1.
//   A bank is marked full one cycle after its last write (so the consumer never
//   sees a partial tile) and cleared when the PE array releases it.
//
// Ports
//   clock, rst_n        system clock, synchronous active-low reset
//   start               begin run (IDLE only); latches tile_len / num_tiles
//   ifm_vld/ifm_rdy     loader handshake, ifm_data is the beat
//   ifm_wr_en/addr/in   registered write port to the channel selector
//   buf_in_switch       pulse with the last write of each tile
//   loop_end            pulse with the last write of the final tile
//   buf_full[1:0]       per-bank complete-tile flags
//   rd_bank/rd_release  bank the consumer reads next / consumer done with it
//   busy, done          run in progress / run complete pulse
//
// Optional build macro IFM_PP_CTRL_ERR_EN adds sticky err + err_code
// (first error wins): 01 stray release, 10 start while busy,
// 11 start with tile_len above buffer depth (run refused). Without it those
// events are ignored and an over-length tile_len is truncated to ADDR_W bits.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | accepting beats into wr_bank
// DRAIN | all tiles written, waiting for both banks to be released
// DONE  | one-cycle completion, done asserted

module ifm_pingpong_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 128,
   parameter int LEN_W  = 11,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  tile_len,
   input  logic [CNT_W-1:0]  num_tiles,
   input  logic              ifm_vld,
   output logic              ifm_rdy,
   input  logic [DATA_W-1:0] ifm_data,
   output logic              ifm_wr_en,
   output logic [ADDR_W-1:0] ifm_wr_addr,
   output logic [DATA_W-1:0] ifm_in,
   output logic              buf_in_switch,
   output logic              loop_end,
   output logic [1:0]        buf_full,
   output logic              rd_bank,
   input  logic              rd_release,
   output logic              busy,
`ifdef IFM_PP_CTRL_ERR_EN
   output logic              err,
   output logic [1:0]        err_code,
`endif
   output logic              done
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

   localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(1) << ADDR_W;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  tile_len_q, tile_len_d;
   logic [CNT_W-1:0]  num_tiles_q, num_tiles_d;
   logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]  tile_cnt_q, tile_cnt_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [1:0]        full_q, full_d;
   logic              set_vld_q, set_vld_d;
   logic              set_bank_q, set_bank_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              switch_q, switch_d;
   logic              loop_end_q, loop_end_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              over_len;
   logic              start_bad;
   logic [LEN_W-1:0]  eff_len;
   logic              accept;
   logic              last_beat;
   logic              final_tile;

   assign over_len  = {1'b0, tile_len} > MAX_LEN;
   assign eff_len   = over_len ? LEN_W'(tile_len[ADDR_W-1:0]) : tile_len;
   assign ifm_rdy   = (state_q == S_FILL) && !full_q[wr_bank_q];
   assign accept    = ifm_rdy && ifm_vld;
   assign last_beat = beat_cnt_q == (tile_len_q - LEN_W'(1));
   assign final_tile = tile_cnt_q == (num_tiles_q - CNT_W'(1));

`ifdef IFM_PP_CTRL_ERR_EN
   logic       err_q, err_d;
   logic [1:0] err_code_q, err_code_d;
   assign start_bad = over_len;
   assign err       = err_q;
   assign err_code  = err_code_q;
`else
   assign start_bad = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      tile_len_d  = tile_len_q;
      num_tiles_d = num_tiles_q;
      beat_cnt_d  = beat_cnt_q;
      tile_cnt_d  = tile_cnt_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      full_d      = full_q;
      set_vld_d   = 1'b0;
      set_bank_d  = set_bank_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      switch_d    = 1'b0;
      loop_end_d  = 1'b0;

      // Deferred full set lands one cycle after the tile's last RAM write.
      if (set_vld_q) full_d[set_bank_q] = 1'b1;
      if (rd_release && full_q[rd_bank_q]) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end

      case (state_q)
         S_IDLE: begin
            if (start && !start_bad) begin
               tile_len_d  = eff_len;
               num_tiles_d = num_tiles;
               beat_cnt_d  = '0;
               tile_cnt_d  = '0;
               wr_bank_d   = 1'b0;
               // An empty run passes through DRAIN so busy spans two cycles.
               state_d = (eff_len == '0 || num_tiles == '0) ? S_DRAIN : S_FILL;
            end
         end
         S_FILL: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = beat_cnt_q[ADDR_W-1:0];
               wr_data_d = ifm_data;
               if (last_beat) begin
                  beat_cnt_d = '0;
                  tile_cnt_d = tile_cnt_q + CNT_W'(1);
                  switch_d   = 1'b1;
                  set_vld_d  = 1'b1;
                  set_bank_d = wr_bank_q;
                  if (final_tile) begin
                     loop_end_d = 1'b1;
                     wr_bank_d  = 1'b0;
                     state_d    = S_DRAIN;
                  end else begin
                     wr_bank_d = ~wr_bank_q;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + LEN_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (full_q == 2'b00 && !set_vld_q) begin
               state_d   = S_DONE;
               rd_bank_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = state_d != S_IDLE;
      done_d = state_d == S_DONE;
   end

`ifdef IFM_PP_CTRL_ERR_EN
   always_comb begin
      err_d      = err_q;
      err_code_d = err_code_q;
      if (!err_q) begin
         if (rd_release && !full_q[rd_bank_q]) begin
            err_d = 1'b1; err_code_d = 2'b01;
         end else if (start && state_q != S_IDLE) begin
            err_d = 1'b1; err_code_d = 2'b10;
         end else if (start && over_len) begin
            err_d = 1'b1; err_code_d = 2'b11;
         end
      end
   end
`endif

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tile_len_q  <= '0;
         num_tiles_q <= '0;
         beat_cnt_q  <= '0;
         tile_cnt_q  <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         full_q      <= 2'b00;
         set_vld_q   <= 1'b0;
         set_bank_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         switch_q    <= 1'b0;
         loop_end_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef IFM_PP_CTRL_ERR_EN
         err_q       <= 1'b0;
         err_code_q  <= 2'b00;
`endif
      end else begin
         state_q     <= state_d;
         tile_len_q  <= tile_len_d;
         num_tiles_q <= num_tiles_d;
         beat_cnt_q  <= beat_cnt_d;
         tile_cnt_q  <= tile_cnt_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         full_q      <= full_d;
         set_vld_q   <= set_vld_d;
         set_bank_q  <= set_bank_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         switch_q    <= switch_d;
         loop_end_q  <= loop_end_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef IFM_PP_CTRL_ERR_EN
         err_q       <= err_d;
         err_code_q  <= err_code_d;
`endif
      end
   end

   assign ifm_wr_en     = wr_en_q;
   assign ifm_wr_addr   = wr_addr_q;
   assign ifm_in        = wr_data_q;
   assign buf_in_switch = switch_q;
   assign loop_end      = loop_end_q;
   assign buf_full      = full_q;
   assign rd_bank       = rd_bank_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_ifm_pingpong_ctrl.sv
// Directed bench for ifm_pingpong_ctrl: tile cutting, bank alternation,
// back-pressure on unreleased banks, mid-run reset and empty runs.

module tb_ifm_pingpong_ctrl;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 128;
   localparam int LEN_W  = 11;
   localparam int CNT_W  = 16;

   logic              clock = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  tile_len = '0;
   logic [CNT_W-1:0]  num_tiles = '0;
   logic              ifm_vld = 1'b0;
   logic              ifm_rdy;
   logic [DATA_W-1:0] ifm_data;
   logic              ifm_wr_en;
   logic [ADDR_W-1:0] ifm_wr_addr;
   logic [DATA_W-1:0] ifm_in;
   logic              buf_in_switch;
   logic              loop_end;
   logic [1:0]        buf_full;
   logic              rd_bank;
   logic              rd_release = 1'b0;
   logic              busy;
   logic              done;
`ifdef IFM_PP_CTRL_ERR_EN
   logic              err;
   logic [1:0]        err_code;
`endif

   always #5 clock = ~clock;

   ifm_pingpong_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)
   ) dut (
      .clock(clock), .rst_n(rst_n), .start(start),
      .tile_len(tile_len), .num_tiles(num_tiles),
      .ifm_vld(ifm_vld), .ifm_rdy(ifm_rdy), .ifm_data(ifm_data),
      .ifm_wr_en(ifm_wr_en), .ifm_wr_addr(ifm_wr_addr), .ifm_in(ifm_in),
      .buf_in_switch(buf_in_switch), .loop_end(loop_end),
      .buf_full(buf_full), .rd_bank(rd_bank), .rd_release(rd_release),
      .busy(busy),
`ifdef IFM_PP_CTRL_ERR_EN
      .err(err), .err_code(err_code),
`endif
      .done(done)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] mk_data(input int i);
      logic [31:0] w;
      w = 32'hA500_0000 + 32'(i);
      return {w, ~w, w ^ 32'h0F0F_0F0F, 32'(i)};
   endfunction

   // Write log captured on the falling edge.
   int                cyc = 0;
   logic [ADDR_W-1:0] q_addr[$];
   logic [DATA_W-1:0] q_data[$];
   logic              q_sw[$];
   logic              q_le[$];
   int                q_cyc[$];

   always @(negedge clock) begin
      cyc++;
      if (ifm_wr_en) begin
         q_addr.push_back(ifm_wr_addr);
         q_data.push_back(ifm_in);
         q_sw.push_back(buf_in_switch);
         q_le.push_back(loop_end);
         q_cyc.push_back(cyc);
      end
   end

   task automatic clear_log();
      q_addr.delete(); q_data.delete(); q_sw.delete(); q_le.delete(); q_cyc.delete();
   endtask

   int   beat_idx = 0;
   logic auto_rel = 1'b0;

   // One clock: accept decision sampled at negedge, inputs updated 1 unit after posedge.
   task automatic step();
      logic acc;
      @(negedge clock);
      acc = ifm_vld && ifm_rdy && rst_n;
      @(posedge clock);
      #1;
      if (acc) begin
         beat_idx++;
         ifm_data = mk_data(beat_idx);
      end
      if (auto_rel) rd_release = buf_full[rd_bank];
   endtask

   task automatic start_run(input int len, input int n);
      tile_len  = LEN_W'(len);
      num_tiles = CNT_W'(n);
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic release_pulse();
      rd_release = 1'b1;
      step();
      rd_release = 1'b0;
   endtask

   task automatic wait_full(input string tag, input logic [1:0] mask, input int max);
      int i = 0;
      while ((buf_full & mask) != mask && i < max) begin
         step();
         i++;
      end
      check_val(tag, 128'((buf_full & mask) == mask), 128'd1);
   endtask

   task automatic wait_done(input string tag, input int max);
      int i = 0;
      while (!done && i < max) begin
         step();
         i++;
      end
      check_val({tag, "_done"}, 128'(done), 128'd1);
      step();
      check_val({tag, "_idle"}, 128'({busy, done, rd_bank}), 128'd0);
   endtask

   task automatic check_tile_log(input string tag, input int n, input int len, input int base);
      check_val({tag, "_nwr"}, 128'(q_addr.size()), 128'(n));
      for (int k = 0; k < n && k < q_addr.size(); k++) begin
         check_val({tag, "_addr"}, 128'(q_addr[k]), 128'(k % len));
         check_val({tag, "_data"}, 128'(q_data[k]), 128'(mk_data(base + k)));
         check_val({tag, "_sw"},   128'(q_sw[k]),   128'((k % len) == len - 1));
         check_val({tag, "_le"},   128'(q_le[k]),   128'(k == n - 1));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
      $fatal(1);
   end

   initial begin
      int base;
      ifm_data = mk_data(0);

      // Reset
      rst_n = 1'b0;
      step(); step();
      check_val("rst_flags", 128'({ifm_rdy, ifm_wr_en, buf_in_switch, loop_end, buf_full, rd_bank, busy, done}), 128'd0);
      check_val("rst_addr", 128'(ifm_wr_addr), 128'd0);
      check_val("rst_data", 128'(ifm_in), 128'd0);
      rst_n = 1'b1;
      step();

      // T1: single 4-beat tile
      ifm_vld = 1'b1;
      clear_log();
      base = beat_idx;
      start_run(4, 1);
      check_val("t1_prewr", 128'({ifm_rdy, ifm_wr_en}), 128'b10);
      step();
      check_val("t1_lat_en",   128'(ifm_wr_en), 128'd1);
      check_val("t1_lat_addr", 128'(ifm_wr_addr), 128'd0);
      check_val("t1_lat_data", 128'(ifm_in), 128'(mk_data(base)));
      wait_full("t1_full", 2'b01, 20);
      check_tile_log("t1", 4, 4, base);
      check_val("t1_bufful", 128'(buf_full), 128'b01);
      step(); step();
      check_val("t1_busy", 128'(busy), 128'd1);
      release_pulse();
      check_val("t1_rel", 128'({buf_full, rd_bank}), 128'b001);
      wait_done("t1", 20);

      // T2: 4 tiles of 3, consumer holds off
      clear_log();
      base = beat_idx;
      start_run(3, 4);
      repeat (12) step();
      check_val("t2_nwr_a", 128'(q_addr.size()), 128'd6);
      check_val("t2_stall_a", 128'({ifm_rdy, buf_full, rd_bank}), 128'b0110);
      release_pulse();
      repeat (8) step();
      check_val("t2_nwr_b", 128'(q_addr.size()), 128'd9);
      check_val("t2_stall_b", 128'({ifm_rdy, buf_full, rd_bank}), 128'b0111);
      release_pulse();
      repeat (8) step();
      check_val("t2_nwr_c", 128'(q_addr.size()), 128'd12);
      check_val("t2_drain", 128'({busy, buf_full, rd_bank}), 128'b1110);
      release_pulse();
      check_val("t2_rel_c", 128'({buf_full, rd_bank}), 128'b101);
      release_pulse();
      check_val("t2_rel_d", 128'(buf_full), 128'b00);
      wait_done("t2", 10);
      check_tile_log("t2", 12, 3, base);

      // T3: 3 tiles of 2 with prompt releases, no bubble
      clear_log();
      base = beat_idx;
      auto_rel = 1'b1;
      start_run(2, 3);
      wait_done("t3", 40);
      auto_rel = 1'b0;
      rd_release = 1'b0;
      check_tile_log("t3", 6, 2, base);
      if (q_cyc.size() == 6)
         check_val("t3_span", 128'(q_cyc[5] - q_cyc[0]), 128'd5);

      // T4: stray release, start while busy
      step();
      release_pulse();
      check_val("t4_stray", 128'({buf_full, rd_bank, busy}), 128'd0);
`ifdef IFM_PP_CTRL_ERR_EN
      check_val("t4_err", 128'({err, err_code}), 128'b101);
`endif
      clear_log();
      base = beat_idx;
      start_run(2, 1);
      step();
      tile_len  = LEN_W'(5);
      num_tiles = CNT_W'(3);
      start     = 1'b1;
      step();
      start     = 1'b0;
      repeat (4) step();
      check_tile_log("t4", 2, 2, base);
      check_val("t4_full", 128'({busy, buf_full}), 128'b101);
      release_pulse();
      wait_done("t4", 10);
`ifdef IFM_PP_CTRL_ERR_EN
      check_val("t4_err_keep", 128'({err, err_code}), 128'b101);
`endif

      // T5: reset in the middle of an 8-beat tile
      clear_log();
      start_run(8, 2);
      repeat (5) step();
      rst_n = 1'b0;
      step();
      check_val("t5_nwr", 128'(q_addr.size()), 128'd5);
      check_val("t5_rst_flags", 128'({ifm_rdy, ifm_wr_en, buf_in_switch, loop_end, buf_full, rd_bank, busy, done}), 128'd0);
      check_val("t5_rst_addr", 128'(ifm_wr_addr), 128'd0);
      check_val("t5_rst_data", 128'(ifm_in), 128'd0);
`ifdef IFM_PP_CTRL_ERR_EN
      check_val("t5_rst_err", 128'({err, err_code}), 128'd0);
`endif
      rst_n = 1'b1;
      step();
      clear_log();
      base = beat_idx;
      start_run(2, 1);
      repeat (4) step();
      check_tile_log("t5", 2, 2, base);
      check_val("t5_bank0", 128'(buf_full), 128'b01);
      release_pulse();
      wait_done("t5", 10);

      // T6: empty run
      clear_log();
      tile_len  = LEN_W'(4);
      num_tiles = CNT_W'(0);
      start     = 1'b1;
      step();
      start     = 1'b0;
      check_val("t6_c1", 128'({busy, done}), 128'b10);
      step();
      check_val("t6_c2", 128'({busy, done}), 128'b11);
      step();
      check_val("t6_c3", 128'({busy, done}), 128'b00);
      check_val("t6_nwr", 128'(q_addr.size()), 128'd0);

`ifdef IFM_PP_CTRL_ERR_EN
      // Over-length tile refused
      tile_len  = LEN_W'(1025);
      num_tiles = CNT_W'(1);
      start     = 1'b1;
      step();
      start     = 1'b0;
      step();
      check_val("t7_refused", 128'(busy), 128'd0);
      check_val("t7_err", 128'({err, err_code}), 128'b111);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
